loopback_ctrl: RTL and testbench
================================

LOOPBACK_CTRL -- requirements
Module: loopback_ctrl

Interface
REQ-001 Parameter: ADC_W, default 12, ADC sample width.
REQ-002 Parameter: DAC_W, default 14, DAC code width; DAC_W >= ADC_W SHALL hold.
REQ-003 Parameter: RAMP_STEP, default 16, ramp increment in DAC codes.
REQ-004 Port: clk  in  1  system clock (50 MHz domain).
REQ-005 Port: rst_n  in  1  reset; one clock, reset asynchronous, active-low.
REQ-006 Port: mode  in  2  source select: 0 passthrough, 1 ramp, 2 hold-last, 3 mute (midscale).
REQ-007 Port: rate_div  in  16  output pacing period minus 1, in clk cycles.
REQ-008 Port: s_axis_tdata  in  ADC_W  ADC sample.
REQ-009 Port: s_axis_tvalid  in  1  ADC sample valid.
REQ-010 Port: s_axis_tready  out  1  ADC sample accept.
REQ-011 Port: m_axis_tdata  out  DAC_W  DAC code.
REQ-012 Port: m_axis_tvalid  out  1  DAC code valid.
REQ-013 Port: m_axis_tready  in  1  DAC ready for a code.
REQ-014 Port: overrun_cnt  out  8  saturating count of dropped ADC samples and missed ticks.
REQ-015 Port: busy  out  1  high while state is SEND.

Function
REQ-016 The pacing counter SHALL count 0..rate_div and assert tick for one cycle on reaching rate_div, then wrap to 0; rate_div=0 gives a tick every cycle.
REQ-017 s_axis_tready SHALL be 1 whenever rst_n is high; every s_axis_tvalid cycle loads a one-entry sample register and sets sample_full.
REQ-018 A sample loaded while sample_full is already set and unsent SHALL overwrite it (newest wins) and increment overrun_cnt.
REQ-019 The FSM SHALL have states IDLE and SEND; IDLE->SEND on tick when the selected source has data; SEND->IDLE on m_axis_tvalid & m_axis_tready.
REQ-020 Source data: mode 0 requires sample_full; modes 1-3 always have data.
REQ-021 Codes are latched at IDLE->SEND: mode 0 {sample, (DAC_W-ADC_W) zeros}, clears sample_full; mode 1 ramp register, then ramp += RAMP_STEP modulo 2^DAC_W; mode 2 last transmitted code; mode 3 2^(DAC_W-1).
REQ-022 m_axis_tvalid SHALL equal (state==SEND); m_axis_tdata SHALL be stable while m_axis_tvalid is high and unaccepted.
REQ-023 A tick occurring while in SEND SHALL be dropped and SHALL increment overrun_cnt.
REQ-024 A sample load and a tick-triggered consume in the same cycle: consume takes the old sample, the new one sets sample_full, no overrun.
REQ-025 Simultaneous overrun sources in one cycle SHALL increment overrun_cnt by 1 only; overrun_cnt SHALL saturate at 255.
REQ-026 mode and rate_div SHALL be sampled only at IDLE->SEND and tick generation respectively; changes never alter a code already in SEND.
REQ-027 Latency: m_axis_tvalid rises the cycle after the qualifying tick.

Reset
REQ-028 On rst_n low: state IDLE, m_axis_tvalid 0, m_axis_tdata 0, s_axis_tready 0, busy 0, overrun_cnt 0, pacing counter 0, ramp 0, last code 2^(DAC_W-1), sample_full 0.
REQ-029 Reset asserted mid-SEND SHALL abandon the transfer immediately; no code is replayed after reset release.

Structure
REQ-030 Mode encodings (MODE_PASS, MODE_RAMP, MODE_HOLD, MODE_MUTE) and FSM state encodings SHALL live in a shared package loopback_pkg.
REQ-031 The pacing counter SHALL be a sub-module rate_ticker (clk, rst_n, rate_div, tick).

Verification
REQ-032 mode=0, rate_div=9, ready=1, samples 0x123 then 0xABC -> m_axis_tdata 0x048C then 0x2AF0, one per 10 cycles.
REQ-033 mode=1, rate_div=0, m_axis_tready=1 -> codes 0,16,32,...; after 16368 next code 0 (wrap).
REQ-034 mode=0, three samples between ticks -> only the third is sent, overrun_cnt=2.
REQ-035 m_axis_tready held low for 50 cycles, rate_div=4 -> tdata stable, overrun_cnt increments per dropped tick (10), busy high throughout.
REQ-036 mode=3 -> 0x2000 every tick; switch to mode=2 -> 0x2000 repeated; reset mid-SEND -> tvalid 0 next edge, overrun_cnt 0.

Source files
------------

// File: rtl/loopback_pkg.sv
// Shared encodings for the ADC-to-DAC loopback controller: source modes,
// FSM states and a saturating counter helper.
package loopback_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_PASS = 2'd0;
   localparam mode_t MODE_RAMP = 2'd1;
   localparam mode_t MODE_HOLD = 2'd2;
   localparam mode_t MODE_MUTE = 2'd3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/rate_ticker.sv
// Free-running pacing counter: one-cycle tick every rate_div+1 clocks.
module rate_ticker (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] rate_div,
   output logic        tick
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // >= rather than == so a rate_div lowered below the running count wraps at once
   assign tick  = (cnt_q >= rate_div);
   assign cnt_d = tick ? 16'd0 : cnt_q + 16'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/loopback_ctrl.sv
// Paced ADC->DAC loopback: selects passthrough, ramp, hold-last or midscale
// codes and emits one per pacing tick over an AXI-stream style handshake.
module loopback_ctrl
   import loopback_pkg::*;
#(
   parameter int ADC_W     = 12,
   parameter int DAC_W     = 14,
   parameter int RAMP_STEP = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       mode,
   input  logic [15:0]      rate_div,
   input  logic [ADC_W-1:0] s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [DAC_W-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic [7:0]       overrun_cnt,
   output logic             busy
);

   localparam logic [DAC_W-1:0] MIDSCALE = {1'b1, {(DAC_W-1){1'b0}}};
   localparam logic [DAC_W-1:0] STEP     = DAC_W'(RAMP_STEP);

   logic             tick;
   logic [0:0]       state_q, state_d;
   logic [DAC_W-1:0] code_q, code_d;
   logic [DAC_W-1:0] last_q, last_d;
   logic [DAC_W-1:0] ramp_q, ramp_d;
   logic [ADC_W-1:0] sample_q, sample_d;
   logic             full_q, full_d;
   logic [7:0]       ovr_q, ovr_d;

   logic             start;
   logic             consume;
   logic             sampleOvr;
   logic             tickOvr;
   logic [DAC_W-1:0] passCode;

   rate_ticker u_ticker (
      .clk      (clk),
      .rst_n    (rst_n),
      .rate_div (rate_div),
      .tick     (tick)
   );

   assign passCode  = DAC_W'(sample_q) << (DAC_W - ADC_W);
   assign start     = (state_q == ST_IDLE) && tick && ((mode != MODE_PASS) || full_q);
   assign consume   = start && (mode == MODE_PASS);
   // A load that coincides with a consume refills the register rather than overwriting
   assign sampleOvr = s_axis_tvalid && full_q && !consume;
   assign tickOvr   = tick && (state_q == ST_SEND);

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      last_d   = last_q;
      ramp_d   = ramp_q;
      sample_d = sample_q;
      full_d   = full_q;
      ovr_d    = ovr_q;

      if (s_axis_tvalid) begin
         sample_d = s_axis_tdata;
         full_d   = 1'b1;
      end else if (consume) begin
         full_d = 1'b0;
      end

      if (sampleOvr || tickOvr) begin
         ovr_d = sat_inc8(ovr_q);
      end

      if (state_q == ST_IDLE) begin
         if (start) begin
            state_d = ST_SEND;
            case (mode)
               MODE_PASS: code_d = passCode;
               MODE_RAMP: begin
                  code_d = ramp_q;
                  ramp_d = ramp_q + STEP;
               end
               MODE_HOLD: code_d = last_q;
               default:   code_d = MIDSCALE;
            endcase
         end
      end else begin
         if (m_axis_tready) begin
            state_d = ST_IDLE;
            last_d  = code_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         code_q   <= '0;
         last_q   <= MIDSCALE;
         ramp_q   <= '0;
         sample_q <= '0;
         full_q   <= 1'b0;
         ovr_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         last_q   <= last_d;
         ramp_q   <= ramp_d;
         sample_q <= sample_d;
         full_q   <= full_d;
         ovr_q    <= ovr_d;
      end
   end

   assign s_axis_tready = rst_n;
   assign m_axis_tvalid = (state_q == ST_SEND);
   assign busy          = (state_q == ST_SEND);
   assign m_axis_tdata  = code_q;
   assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_loopback_ctrl.sv
// Scoreboard bench for loopback_ctrl: directed phases push expected DAC codes,
// a negedge monitor pops and compares each accepted transfer.
module tb_loopback_ctrl;
   import loopback_pkg::*;

   localparam int ADC_W = 12;
   localparam int DAC_W = 14;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       mode = MODE_PASS;
   logic [15:0]      rate_div = 16'd9;
   logic [ADC_W-1:0] s_axis_tdata = '0;
   logic             s_axis_tvalid = 1'b0;
   logic             s_axis_tready;
   logic [DAC_W-1:0] m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready = 1'b1;
   logic [7:0]       overrun_cnt;
   logic             busy;

   int total = 0;
   int bad   = 0;
   logic [DAC_W-1:0] expQ[$];

   loopback_ctrl #(.ADC_W(ADC_W), .DAC_W(DAC_W), .RAMP_STEP(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mode          (mode),
      .rate_div      (rate_div),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .overrun_cnt   (overrun_cnt),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Each negedge with valid&ready is exactly one transfer accepted at the next posedge
   always @(negedge clk) begin
      if (rst_n && m_axis_tvalid && m_axis_tready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected code", 32'(m_axis_tdata), 32'hFFFF_FFFF);
         end else begin
            checkOutput("dac code", 32'(m_axis_tdata), 32'(expQ.pop_front()));
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [ADC_W-1:0] data);
      s_axis_tdata  = data;
      s_axis_tvalid = 1'b1;
      waitCycles(1);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic waitDrain(input int maxCycles, input string name);
      int n = 0;
      while (expQ.size() != 0 && n < maxCycles) begin
         waitCycles(1);
         n++;
      end
      checkOutput(name, 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   task automatic doReset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("reset tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("reset tdata", 32'(m_axis_tdata), 32'd0);
      checkOutput("reset tready", 32'(s_axis_tready), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset overrun", 32'(overrun_cnt), 32'd0);
      expQ.delete();
      s_axis_tvalid = 1'b0;
      waitCycles(2);
      rst_n = 1'b1;
   endtask

   initial begin
      int n;

      // Passthrough, one sample per tick
      doReset();
      mode = MODE_PASS; rate_div = 16'd9; m_axis_tready = 1'b1;
      #1 checkOutput("tready out of reset", 32'(s_axis_tready), 32'd1);
      waitCycles(1);
      applyStimulus(12'h123);
      expQ.push_back(14'h048C);
      waitDrain(15, "pass first drain");
      applyStimulus(12'hABC);
      expQ.push_back(14'h2AF0);
      waitDrain(15, "pass second drain");
      checkOutput("pass overrun", 32'(overrun_cnt), 32'd0);

      // Load coinciding with the consuming tick: old sample sent, new one kept
      doReset();
      waitCycles(1);
      applyStimulus(12'h111);
      waitCycles(7);
      applyStimulus(12'h222);
      expQ.push_back(14'h0444);
      expQ.push_back(14'h0888);
      waitDrain(25, "coincident drain");
      checkOutput("coincident overrun", 32'(overrun_cnt), 32'd0);

      // Three samples between ticks: newest wins, two overruns
      doReset();
      waitCycles(1);
      s_axis_tvalid = 1'b1; s_axis_tdata = 12'h001;
      waitCycles(1);
      s_axis_tdata = 12'h002;
      waitCycles(1);
      s_axis_tdata = 12'h3FF;
      waitCycles(1);
      s_axis_tvalid = 1'b0;
      expQ.push_back(14'h0FFC);
      waitDrain(15, "newest wins drain");
      checkOutput("newest wins overrun", 32'(overrun_cnt), 32'd2);

      // Backpressure: code held, dropped ticks counted, mode change ignored
      doReset();
      mode = MODE_MUTE; rate_div = 16'd4; m_axis_tready = 1'b0;
      waitCycles(5);
      for (int i = 0; i < 50; i++) begin
         checkOutput("stall busy", 32'(busy), 32'd1);
         checkOutput("stall tvalid", 32'(m_axis_tvalid), 32'd1);
         checkOutput("stall tdata", 32'(m_axis_tdata), 32'h2000);
         if (i == 15) mode = MODE_RAMP;
         waitCycles(1);
      end
      checkOutput("stall overrun", 32'(overrun_cnt), 32'd10);
      expQ.push_back(14'h2000);
      mode = MODE_PASS; m_axis_tready = 1'b1;
      waitDrain(5, "stall release drain");
      checkOutput("stall busy after", 32'(busy), 32'd0);
      checkOutput("stall overrun after", 32'(overrun_cnt), 32'd10);

      // Ramp every tick through the wrap, overrun saturates
      doReset();
      mode = MODE_RAMP; rate_div = 16'd0; m_axis_tready = 1'b1;
      for (int k = 0; k < 1026; k++) expQ.push_back(DAC_W'(k * 16));
      waitDrain(2200, "ramp drain");
      mode = MODE_HOLD; m_axis_tready = 1'b0;
      checkOutput("ramp overrun saturate", 32'(overrun_cnt), 32'd255);
      n = 0;
      while (!busy && n < 5) begin
         waitCycles(1);
         n++;
      end
      checkOutput("hold enters send", 32'(busy), 32'd1);
      checkOutput("hold last ramp code", 32'(m_axis_tdata), 32'd16);

      // Reset mid-SEND abandons the transfer; hold restarts from midscale
      doReset();
      mode = MODE_HOLD; m_axis_tready = 1'b1;
      expQ.push_back(14'h2000);
      waitDrain(10, "hold after reset drain");
      mode = MODE_PASS;

      // Mute then hold-last
      doReset();
      mode = MODE_MUTE; rate_div = 16'd3; m_axis_tready = 1'b1;
      repeat (3) expQ.push_back(14'h2000);
      waitDrain(20, "mute drain");
      mode = MODE_HOLD;
      repeat (3) expQ.push_back(14'h2000);
      waitDrain(20, "hold drain");
      mode = MODE_PASS;
      checkOutput("mute hold overrun", 32'(overrun_cnt), 32'd0);

      waitCycles(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
